mux8x1_scan_driver: RTL and testbench

- Upstream driver for the 8:1 enabled mux (mux8x1_with_en).
- Accepts one parallel word over a valid/ready handshake and holds it on the mux data bus.
- Sweeps the mux select through every index with the mux enable active (active-low), then signals completion.
- Net effect: the word is serialised through the mux, one bit per select step.

---
 rtl/mux_scan_pkg.sv | 8 +
 rtl/mux_scan_dwell_timer.sv | 19 +
 rtl/mux8x1_scan_driver.sv | 90 +++++++++
 tb/tb_mux8x1_scan_driver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state type, enable polarity and default geometry for the mux scan driver.
package mux_scan_pkg;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic EN_ACTIVE = 1'b0;
  localparam logic EN_IDLE = 1'b1;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_SEL_W = 3;
endpackage

// File: rtl/mux_scan_dwell_timer.sv
// mux_scan_dwell_timer: counts cycles on one select index and pulses step on the last one.
module mux_scan_dwell_timer #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic step
);
  localparam int CW = $clog2(DWELL + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    step = !clr && cnt_q == CW'(DWELL - 1);
    cnt_d = (clr || step) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mux8x1_scan_driver.sv
// mux8x1_scan_driver: accepts a word and sweeps the 8:1 mux select across it; MUX_SCAN_MSB_FIRST_EN scans high index first.
module mux8x1_scan_driver import mux_scan_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W,
  parameter int DWELL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic [WIDTH-1:0] datain,
  output logic [SEL_W-1:0] s,
  output logic             en,
  output logic             busy,
  output logic             done
);
`ifdef MUX_SCAN_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] FIRST = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] LAST = '0;
`else
  localparam logic [SEL_W-1:0] FIRST = '0;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] datain_q, datain_d;
  logic [SEL_W-1:0] s_q, s_d, s_step;
  logic en_q, en_d, busy_q, busy_d, done_q, done_d, idle, step;
  assign idle = state_q == IDLE;
  assign in_ready = idle;
  assign datain = datain_q;
  assign s = s_q;
  assign en = en_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef MUX_SCAN_MSB_FIRST_EN
  assign s_step = s_q - SEL_W'(1);
`else
  assign s_step = s_q + SEL_W'(1);
`endif
  // Timer is held clear in IDLE so every scan starts with a full dwell.
  mux_scan_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(idle),
    .step(step)
  );
  always_comb begin
    state_d = state_q;
    datain_d = datain_q;
    s_d = s_q;
    en_d = en_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (idle) begin
      if (in_valid) begin
        state_d = SCAN;
        datain_d = in_data;
        s_d = FIRST;
        en_d = EN_ACTIVE;
        busy_d = 1'b1;
      end
    end else if (abort || (step && s_q == LAST)) begin
      state_d = IDLE;
      s_d = '0;
      en_d = EN_IDLE;
      busy_d = 1'b0;
      done_d = !abort;
    end else if (step) begin
      s_d = s_step;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      datain_q <= '0;
      s_q <= '0;
      en_q <= EN_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      datain_q <= datain_d;
      s_q <= s_d;
      en_q <= en_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
endmodule

// File: tb/tb_mux8x1_scan_driver.sv
// tb_mux8x1_scan_driver: two driver instances (DWELL 1 and 3) checked cycle by cycle against an elapsed-time model.
module tb_mux8x1_scan_driver;
`ifdef MUX_SCAN_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif
  localparam logic [14:0] RST_V = {1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vin[2];
  logic [7:0] din[2];
  logic ab[2];
  logic rdy_o[2], en_o[2], busy_o[2], done_o[2];
  logic [7:0] dat_o[2];
  logic [2:0] s_o[2];
  int checks = 0;
  int errors = 0;
  bit m_scan[2];
  bit m_done[2];
  int m_t[2];
  logic [7:0] m_word[2];

  always #5 clk = ~clk;

  mux8x1_scan_driver #(.WIDTH(8), .SEL_W(3), .DWELL(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(vin[0]), .in_ready(rdy_o[0]), .in_data(din[0]),
    .abort(ab[0]), .datain(dat_o[0]), .s(s_o[0]), .en(en_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );
  mux8x1_scan_driver #(.WIDTH(8), .SEL_W(3), .DWELL(3)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(vin[1]), .in_ready(rdy_o[1]), .in_data(din[1]),
    .abort(ab[1]), .datain(dat_o[1]), .s(s_o[1]), .en(en_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  function automatic int dw(int k);
    return k == 0 ? 1 : 3;
  endfunction

  // Reference: a scan is just "cycles elapsed since accept"; index = elapsed / DWELL.
  always @(posedge clk or posedge rst)
    for (int k = 0; k < 2; k++)
      if (rst) begin
        m_scan[k] = 0; m_done[k] = 0; m_t[k] = 0; m_word[k] = 8'h00;
      end else begin
        m_done[k] = 0;
        if (!m_scan[k]) begin
          if (vin[k]) begin m_scan[k] = 1; m_t[k] = 0; m_word[k] = din[k]; end
        end else if (ab[k]) m_scan[k] = 0;
        else if (m_t[k] == 8 * dw(k) - 1) begin m_scan[k] = 0; m_done[k] = 1; end
        else m_t[k]++;
      end

  function automatic int m_idx(int k);
    int i;
    i = m_t[k] / dw(k);
    return MSB ? 7 - i : i;
  endfunction

  function automatic logic [14:0] exp_v(int k);
    return {!m_scan[k], m_scan[k], m_done[k], !m_scan[k], m_scan[k] ? 3'(m_idx(k)) : 3'd0, m_word[k]};
  endfunction

  function automatic logic [14:0] obs_v(int k);
    return {rdy_o[k], busy_o[k], done_o[k], en_o[k], s_o[k], dat_o[k]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v(k) !== RST_V) begin
          errors++;
          $display("FAIL reset_hold k=%0d actual=%h required=%h", k, obs_v(k), RST_V);
        end
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_v(k) !== RST_V) begin
        errors++;
        $display("FAIL reset_release k=%0d actual=%h required=%h", k, obs_v(k), RST_V);
      end
    end
  endtask

  task automatic test_scan(int k, logic [7:0] w, string name);
    int en_lo = 0, dn = 0;
    logic [7:0] ser = '0, ser_exp = '0;
    vin[k] = 1'b1; din[k] = w;
    @(negedge clk);
    vin[k] = 1'b0; din[k] = $urandom;
    for (int c = 0; c < 8 * dw(k) + 3; c++) begin
      checks++;
      if (obs_v(k) !== exp_v(k)) begin
        errors++;
        $display("FAIL %s c=%0d actual=%h required=%h", name, c, obs_v(k), exp_v(k));
      end
      if (en_o[k] === 1'b0) en_lo++;
      if (done_o[k] === 1'b1) dn++;
      if (c < 8 * dw(k) && c % dw(k) == 0) begin
        ser = {ser[6:0], dat_o[k][s_o[k]]};
        ser_exp = {ser_exp[6:0], w[MSB ? 7 - c / dw(k) : c / dw(k)]};
      end
      @(negedge clk);
    end
    checks++;
    if (en_lo != 8 * dw(k)) begin
      errors++;
      $display("FAIL %s_en_cycles actual=%0d required=%0d", name, en_lo, 8 * dw(k));
    end
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL %s_done_count actual=%0d required=1", name, dn);
    end
    checks++;
    if (ser !== ser_exp) begin
      errors++;
      $display("FAIL %s_serial actual=%h required=%h", name, ser, ser_exp);
    end
  endtask

  task automatic test_back_to_back(int k);
    bit again = 0;
    int starts = 0;
    logic [7:0] nw = 8'($urandom);
    vin[k] = 1'b1; din[k] = 8'h0C;
    @(negedge clk);
    vin[k] = 1'b0;
    for (int c = 0; c < 16 * dw(k) + 6; c++) begin
      checks++;
      if (obs_v(k) !== exp_v(k)) begin
        errors++;
        $display("FAIL back_to_back c=%0d actual=%h required=%h", c, obs_v(k), exp_v(k));
      end
      if (again && busy_o[k] === 1'b1 && dat_o[k] === nw) starts++;
      vin[k] = 1'b0;
      if (c == 4) begin vin[k] = 1'b1; din[k] = 8'hFF; end
      if (m_done[k] && !again) begin vin[k] = 1'b1; din[k] = nw; again = 1; end
      @(negedge clk);
    end
    vin[k] = 1'b0;
    checks++;
    if (starts != 8 * dw(k)) begin
      errors++;
      $display("FAIL back_to_back_second_scan actual=%0d required=%0d", starts, 8 * dw(k));
    end
  endtask

  task automatic test_abort(int k, int at_t, string name);
    int dn = 0;
    bit fired = 0;
    vin[k] = 1'b1; din[k] = 8'($urandom);
    @(negedge clk);
    vin[k] = 1'b0;
    for (int c = 0; c < 8 * dw(k) + 4; c++) begin
      checks++;
      if (obs_v(k) !== exp_v(k)) begin
        errors++;
        $display("FAIL %s c=%0d actual=%h required=%h", name, c, obs_v(k), exp_v(k));
      end
      if (done_o[k] === 1'b1) dn++;
      ab[k] = 1'b0;
      if (m_scan[k] && m_t[k] == at_t && !fired) begin ab[k] = 1'b1; fired = 1; end
      if (!m_scan[k] && c > 8 * dw(k)) ab[k] = 1'b1;
      @(negedge clk);
    end
    ab[k] = 1'b0;
    checks++;
    if (dn != 0 || !fired) begin
      errors++;
      $display("FAIL %s_no_done actual=%0d fired=%0d required=0 fired=1", name, dn, fired);
    end
  endtask

  task automatic test_rst_mid();
    int n = 0;
    for (int k = 0; k < 2; k++) begin vin[k] = 1'b1; din[k] = 8'($urandom_range(1, 255)); end
    @(negedge clk);
    for (int k = 0; k < 2; k++) vin[k] = 1'b0;
    while (!(m_scan[1] && m_t[1] / 3 == (MSB ? 2 : 5)) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL rst_mid_wait actual=timeout required=s5");
    end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_v(k) !== RST_V) begin
        errors++;
        $display("FAIL rst_mid k=%0d actual=%h required=%h", k, obs_v(k), RST_V);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_v(k) !== exp_v(k)) begin
        errors++;
        $display("FAIL rst_mid_after k=%0d actual=%h required=%h", k, obs_v(k), exp_v(k));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v(k) !== exp_v(k)) begin
          errors++;
          $display("FAIL random c=%0d k=%0d actual=%h required=%h", c, k, obs_v(k), exp_v(k));
        end
        vin[k] = $urandom_range(0, 3) == 0;
        din[k] = 8'($urandom);
        ab[k] = $urandom_range(0, 19) == 0;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin vin[k] = 1'b0; ab[k] = 1'b0; end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin vin[k] = 1'b0; din[k] = 8'h00; ab[k] = 1'b0; end
    test_reset();
    test_scan(0, 8'h0C, "scan_d1_0c");
    test_scan(1, 8'hA5, "scan_d3_a5");
    test_scan(0, 8'($urandom), "scan_d1_rand");
    test_scan(1, 8'($urandom), "scan_d3_rand");
    test_back_to_back(1);
    test_back_to_back(0);
    test_abort(1, 12, "abort_s4_d3");
    test_abort(0, 4, "abort_s4_d1");
    test_abort(1, 23, "abort_last_d3");
    test_abort(0, 7, "abort_last_d1");
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
